// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared definitions for the router read side.
//               Contents: FSM state encoding, header field positions,
//               channel count, the idle channel code and a modulo-3
//               step helper used by the round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int         NUM_CH    = 3;
    localparam logic [1:0] CHAN_IDLE = 2'b11;

    // Header byte layout: {len[7:2], addr[1:0]}
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } rd_state_e;

    // Channel index reached by stepping 'step' places from 'base' around
    // the ring of NUM_CH channels.
    function automatic logic [1:0] rr_next(input logic [1:0] base,
                                           input int unsigned step);
        return 2'((32'(base) + step) % 32'(NUM_CH));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_3.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_3
// Description : Combinational three-way round-robin arbiter.
//               Requests are scanned in the order rr_ptr+1, rr_ptr+2,
//               rr_ptr (mod 3); the first asserted request wins, so the
//               channel served last has the lowest priority.
// Ports       : i_req         - request vector, one bit per channel
//               i_rr_ptr      - channel served most recently
//               o_grant       - index of the winning channel
//               o_grant_valid - at least one request is asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_3
    import router_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_rr_ptr,
    output logic [1:0] o_grant,
    output logic       o_grant_valid
);

    // Padded so a 2-bit index can never fall outside the vector.
    logic [3:0] w_req_pad;
    assign w_req_pad = {1'b0, i_req};

    // Walk the ring from the lowest priority to the highest; a later hit
    // overwrites an earlier one, leaving the highest-priority requester.
    always_comb begin
        logic [1:0] w_idx;
        o_grant       = 2'd0;
        o_grant_valid = 1'b0;
        w_idx         = 2'd0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = rr_next(i_rr_ptr, k);
            if (w_req_pad[w_idx]) begin
                o_grant       = w_idx;
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : router_read_arbiter
// Description : Reader side of the router's three output FIFOs. Picks a
//               non-empty FIFO by round robin, pops one complete packet
//               (header, len payload bytes, parity) one byte at a time and
//               hands each byte to the UART transmitter over valid/ready.
//               A soft reset on the channel being served drops the packet.
// Ports       : clock, resetn            - clock, async active-low reset
//               vld_out_0..2             - FIFO non-empty flags
//               soft_reset_0..2          - FIFO flushed by synchronizer
//               data_out_0..2            - FIFO read data (1 cycle latency)
//               tx_ready                 - transmitter can take a byte
//               read_enb_0..2            - FIFO pop strobes
//               tx_data, tx_valid        - byte toward the transmitter
//               busy, chan               - packet in progress / channel
//               pkt_done, pkt_abort      - end-of-packet status pulses
// Revision    : 1.0 - initial release
// ============================================================================
module router_read_arbiter
    import router_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
)
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              vld_out_0,
    input  logic              vld_out_1,
    input  logic              vld_out_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic [DATA_W-1:0] data_out_0,
    input  logic [DATA_W-1:0] data_out_1,
    input  logic [DATA_W-1:0] data_out_2,
    input  logic              tx_ready,
    output logic              read_enb_0,
    output logic              read_enb_1,
    output logic              read_enb_2,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              busy,
    output logic [1:0]        chan,
    output logic              pkt_done,
    output logic              pkt_abort
);

    localparam logic [LEN_W:0] C_REM_ONE = {{LEN_W{1'b0}}, 1'b1};

    rd_state_e         state_q,       state_d;
    logic [1:0]        sel_q,         sel_d;
    logic [1:0]        rr_ptr_q,      rr_ptr_d;
    logic [LEN_W:0]    remaining_q,   remaining_d;
    logic              hdr_pending_q, hdr_pending_d;
    logic [DATA_W-1:0] tx_data_q,     tx_data_d;
    logic              tx_valid_q,    tx_valid_d;
    logic              pkt_done_q,    pkt_done_d;
    logic              pkt_abort_q,   pkt_abort_d;

    logic [3:0]        w_vld;
    logic [3:0]        w_soft;
    logic [DATA_W-1:0] w_sel_data;
    logic [1:0]        w_grant;
    logic              w_grant_valid;
    logic              w_abort;
    logic              w_rd_fire;

    // Vectors padded to four entries so indexing by sel_q stays in range.
    assign w_vld  = {1'b0, vld_out_2, vld_out_1, vld_out_0};
    assign w_soft = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

    always_comb begin
        case (sel_q)
            2'd0:    w_sel_data = data_out_0;
            2'd1:    w_sel_data = data_out_1;
            2'd2:    w_sel_data = data_out_2;
            default: w_sel_data = '0;
        endcase
    end

    rr_arbiter_3 u_rr_arbiter (
        .i_req         (w_vld[2:0]),
        .i_rr_ptr      (rr_ptr_q),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    // Only the channel being served can abort a packet.
    assign w_abort = (state_q != ST_IDLE) && w_soft[sel_q];

    // No pop while aborting: the FIFO is being flushed anyway.
    assign w_rd_fire = (state_q == ST_RD_REQ) && w_vld[sel_q] && !w_abort;

    assign read_enb_0 = w_rd_fire && (sel_q == 2'd0);
    assign read_enb_1 = w_rd_fire && (sel_q == 2'd1);
    assign read_enb_2 = w_rd_fire && (sel_q == 2'd2);

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        rr_ptr_d      = rr_ptr_q;
        remaining_d   = remaining_q;
        hdr_pending_d = hdr_pending_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        pkt_done_d    = 1'b0;
        pkt_abort_d   = 1'b0;

        if (w_abort) begin
            // Withdraw any byte still on offer; abort overrides a
            // simultaneous handshake, so pkt_done never fires here.
            state_d     = ST_IDLE;
            tx_valid_d  = 1'b0;
            pkt_abort_d = 1'b1;
            rr_ptr_d    = sel_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        sel_d         = w_grant;
                        remaining_d   = '0;
                        hdr_pending_d = 1'b1;
                        state_d       = ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    // An empty FIFO mid-packet just stalls here.
                    if (w_vld[sel_q]) begin
                        state_d = ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    tx_data_d  = w_sel_data;
                    tx_valid_d = 1'b1;
                    if (hdr_pending_q) begin
                        // Bytes still to come: payload plus parity.
                        remaining_d   = {1'b0, w_sel_data[LEN_MSB:LEN_LSB]} + C_REM_ONE;
                        hdr_pending_d = 1'b0;
                    end else begin
                        remaining_d = remaining_q - C_REM_ONE;
                    end
                    state_d = ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        state_d    = (remaining_q == '0) ? ST_DONE : ST_RD_REQ;
                    end
                end
                ST_DONE: begin
                    pkt_done_d = 1'b1;
                    rr_ptr_d   = sel_q;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            sel_q         <= 2'd0;
            rr_ptr_q      <= 2'd2;
            remaining_q   <= '0;
            hdr_pending_q <= 1'b0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            pkt_done_q    <= 1'b0;
            pkt_abort_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            rr_ptr_q      <= rr_ptr_d;
            remaining_q   <= remaining_d;
            hdr_pending_q <= hdr_pending_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            pkt_done_q    <= pkt_done_d;
            pkt_abort_q   <= pkt_abort_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign chan      = busy ? sel_q : CHAN_IDLE;
    assign pkt_done  = pkt_done_q;
    assign pkt_abort = pkt_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_router_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_read_arbiter
// Description : Directed self-checking bench for router_read_arbiter with
//               behavioural FIFO models on all three channels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_read_arbiter;

    logic       clock = 1'b0;
    logic       resetn;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic [7:0] data_out_0, data_out_1, data_out_2;
    logic       tx_ready;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic [1:0] chan;
    logic       pkt_done;
    logic       pkt_abort;

    always #5 clock = ~clock;

    router_read_arbiter #(.DATA_W(8), .LEN_W(6)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .vld_out_0    (vld_out_0),
        .vld_out_1    (vld_out_1),
        .vld_out_2    (vld_out_2),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2),
        .data_out_0   (data_out_0),
        .data_out_1   (data_out_1),
        .data_out_2   (data_out_2),
        .tx_ready     (tx_ready),
        .read_enb_0   (read_enb_0),
        .read_enb_1   (read_enb_1),
        .read_enb_2   (read_enb_2),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .busy         (busy),
        .chan         (chan),
        .pkt_done     (pkt_done),
        .pkt_abort    (pkt_abort)
    );

    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] q0[$], q1[$], q2[$];
    logic [2:0] mask;
    logic [7:0] tx_log[$];
    logic [1:0] hs_chan[$];
    int         hs_cyc[$];
    logic [1:0] grant_log[$];
    int         rd_cnt[3];
    int         done_cnt, abort_cnt, dual_cnt, cyc_no, first_busy, first_txv;
    logic       prev_busy;
    logic [7:0] exp_b[$];
    logic [1:0] exp_g[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bytes(input string tag);
        chk({tag, "_count"}, tx_log.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            chk(tag, (i < tx_log.size()) ? {24'd0, tx_log[i]} : 32'hFFFF_FFFF, {24'd0, exp_b[i]});
    endtask

    task automatic chk_grants(input string tag);
        chk({tag, "_count"}, grant_log.size(), exp_g.size());
        for (int i = 0; i < exp_g.size(); i++)
            chk(tag, (i < grant_log.size()) ? {30'd0, grant_log[i]} : 32'hFFFF_FFFF, {30'd0, exp_g[i]});
    endtask

    task automatic refresh_vld();
        vld_out_0 = (q0.size() != 0) && !mask[0];
        vld_out_1 = (q1.size() != 0) && !mask[1];
        vld_out_2 = (q2.size() != 0) && !mask[2];
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        case (ch)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
        refresh_vld();
    endtask

    task automatic clear_mon();
        tx_log.delete(); hs_chan.delete(); hs_cyc.delete(); grant_log.delete();
        for (int i = 0; i < 3; i++) rd_cnt[i] = 0;
        done_cnt = 0; abort_cnt = 0; dual_cnt = 0;
        first_busy = -1; first_txv = -1;
    endtask

    // One clock: observe settled outputs at the falling edge, then model the
    // FIFOs just after the rising edge (pop lands one cycle after read_enb).
    task automatic cyc();
        logic [2:0] en;
        @(negedge clock);
        cyc_no++;
        en = {read_enb_2, read_enb_1, read_enb_0};
        if ($countones(en) > 1) dual_cnt++;
        for (int i = 0; i < 3; i++) if (en[i]) rd_cnt[i]++;
        if (tx_valid && tx_ready) begin
            tx_log.push_back(tx_data);
            hs_chan.push_back(chan);
            hs_cyc.push_back(cyc_no);
        end
        if (pkt_done)  done_cnt++;
        if (pkt_abort) abort_cnt++;
        if (busy && !prev_busy) grant_log.push_back(chan);
        if (busy && first_busy < 0) first_busy = cyc_no;
        if (tx_valid && first_txv < 0) first_txv = cyc_no;
        prev_busy = busy;
        @(posedge clock);
        #1;
        if (en[0] && q0.size() != 0) data_out_0 = q0.pop_front();
        if (en[1] && q1.size() != 0) data_out_1 = q1.pop_front();
        if (en[2] && q2.size() != 0) data_out_2 = q2.pop_front();
        refresh_vld();
    endtask

    task automatic reset_all();
        resetn = 1'b0;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        tx_ready = 1'b0;
        mask = 3'b000;
        q0.delete(); q1.delete(); q2.delete();
        data_out_0 = 8'h00; data_out_1 = 8'h00; data_out_2 = 8'h00;
        refresh_vld();
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        prev_busy = 1'b0;
        clear_mon();
    endtask

    task automatic run_done(input int target, input int max_cyc, input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done_cnt >= target) begin ok = 1'b1; break; end
            cyc();
        end
        chk({tag, "_timeout"}, ok, 1);
    endtask

    task automatic run_txlen(input int n, input int max_cyc, input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (tx_log.size() >= n) begin ok = 1'b1; break; end
            cyc();
        end
        chk({tag, "_timeout"}, ok, 1);
    endtask

    task automatic run_txvalid(input int max_cyc, input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (tx_valid === 1'b1) begin ok = 1'b1; break; end
            cyc();
        end
        chk({tag, "_timeout"}, ok, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"},    {read_enb_2, read_enb_1, read_enb_0}, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"},  tx_data, 0);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_chan"},     chan, 2'b11);
        chk({tag, "_done"},     pkt_done, 0);
        chk({tag, "_abort"},    pkt_abort, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        cyc_no = 0;
        reset_all();
        #1;
        chk_reset_outputs("reset");

        // T1: single len=1 packet on FIFO 0
        tx_ready = 1'b1;
        push(0, 8'h05); push(0, 8'hAA); push(0, 8'h5E);
        run_done(1, 60, "t1");
        repeat (2) cyc();
        exp_b = {8'h05, 8'hAA, 8'h5E};
        chk_bytes("t1_tx");
        chk("t1_rd0", rd_cnt[0], 3);
        chk("t1_done", done_cnt, 1);
        chk("t1_abort", abort_cnt, 0);
        for (int i = 0; i < hs_chan.size(); i++) chk("t1_chan", hs_chan[i], 0);
        chk("t1_latency", first_txv - first_busy, 2);
        chk("t1_gap", (hs_cyc.size() >= 2) ? hs_cyc[1] - hs_cyc[0] : -1, 3);
        chk("t1_idle_chan", chan, 2'b11);

        // T2: len=0 packets everywhere, FIFO 0 holding two
        reset_all();
        tx_ready = 1'b1;
        push(0, 8'h00); push(0, 8'h11); push(0, 8'h00); push(0, 8'h33);
        push(1, 8'h01); push(1, 8'h22);
        push(2, 8'h02); push(2, 8'h44);
        run_done(4, 150, "t2");
        repeat (2) cyc();
        exp_g = {2'd0, 2'd1, 2'd2, 2'd0};
        chk_grants("t2_order");
        exp_b = {8'h00, 8'h11, 8'h01, 8'h22, 8'h02, 8'h44, 8'h00, 8'h33};
        chk_bytes("t2_tx");
        chk("t2_dual_rd", dual_cnt, 0);
        chk("t2_done", done_cnt, 4);

        // T3: back-pressure for 10 cycles on a payload byte
        reset_all();
        tx_ready = 1'b1;
        push(0, 8'h08); push(0, 8'hB1); push(0, 8'hB2); push(0, 8'hC3);
        run_txlen(1, 30, "t3_hdr");
        tx_ready = 1'b0;
        run_txvalid(20, "t3_txv");
        chk("t3_rd_before", rd_cnt[0], 2);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t3_hold_valid", tx_valid, 1);
            chk("t3_hold_data", tx_data, 8'hB1);
        end
        chk("t3_rd_stall", rd_cnt[0], 2);
        tx_ready = 1'b1;
        run_done(1, 60, "t3");
        repeat (2) cyc();
        exp_b = {8'h08, 8'hB1, 8'hB2, 8'hC3};
        chk_bytes("t3_tx");
        chk("t3_rd0", rd_cnt[0], 4);

        // T4: FIFO 1 runs dry for 5 cycles mid-packet
        reset_all();
        tx_ready = 1'b1;
        push(1, 8'h05); push(1, 8'h66); push(1, 8'h77);
        run_txlen(1, 30, "t4_hdr");
        mask[1] = 1'b1;
        refresh_vld();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_stall_busy", busy, 1);
            chk("t4_stall_rd", read_enb_1, 0);
        end
        chk("t4_rd_stall", rd_cnt[1], 1);
        chk("t4_txv_stall", tx_valid, 0);
        mask[1] = 1'b0;
        refresh_vld();
        run_done(1, 60, "t4");
        repeat (2) cyc();
        exp_b = {8'h05, 8'h66, 8'h77};
        chk_bytes("t4_tx");
        chk("t4_rd1", rd_cnt[1], 3);

        // T5: soft reset of channel 2 while its header waits in SEND
        reset_all();
        tx_ready = 1'b1;
        push(1, 8'h01); push(1, 8'h5A);
        run_done(1, 40, "t5_pre");
        tx_ready = 1'b0;
        push(2, 8'h0A); push(2, 8'hD1); push(2, 8'hD2); push(2, 8'hE3);
        run_txvalid(30, "t5_txv");
        chk("t5_chan", chan, 2);
        soft_reset_2 = 1'b1;
        cyc();
        soft_reset_2 = 1'b0;
        q2.delete();
        refresh_vld();
        chk("t5_abort_txv", tx_valid, 0);
        chk("t5_abort_pulse", pkt_abort, 1);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_chan", chan, 2'b11);
        push(0, 8'h00); push(0, 8'hF0);
        push(1, 8'h01); push(1, 8'hF1);
        push(2, 8'h02); push(2, 8'hF2);
        tx_ready = 1'b1;
        cyc();
        chk("t5_abort_width", pkt_abort, 0);
        run_done(4, 150, "t5");
        repeat (2) cyc();
        exp_g = {2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        chk_grants("t5_order");
        exp_b = {8'h01, 8'h5A, 8'h00, 8'hF0, 8'h01, 8'hF1, 8'h02, 8'hF2};
        chk_bytes("t5_tx");
        chk("t5_abort_cnt", abort_cnt, 1);
        chk("t5_done", done_cnt, 4);

        // T6: asynchronous reset between clock edges mid-packet
        reset_all();
        tx_ready = 1'b0;
        push(0, 8'h05); push(0, 8'hAA); push(0, 8'h5E);
        run_txvalid(20, "t6_txv");
        chk("t6_busy_pre", busy, 1);
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        reset_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/router_read_arbiter.md
Name: router_read_arbiter

Overview:
Reader side of the router's three output FIFOs; drains them toward the UART transmitter.
- Selects one channel with valid data by round-robin and reads one whole packet: header, payload, parity.
- Drives the per-channel read enables and forwards each byte to the transmitter over a valid/ready handshake.
- Aborts cleanly when the synchronizer fires a channel's soft reset.

Parameters:
DATA_W, 8, byte width of FIFO data and tx_data; header layout below requires DATA_W = 8
LEN_W, 6, payload-length field width, taken from header bits [7:2]

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
vld_out_0  input  1  FIFO 0 non-empty
vld_out_1  input  1  FIFO 1 non-empty
vld_out_2  input  1  FIFO 2 non-empty
soft_reset_0  input  1  FIFO 0 flushed by synchronizer timeout
soft_reset_1  input  1  FIFO 1 flushed by synchronizer timeout
soft_reset_2  input  1  FIFO 2 flushed by synchronizer timeout
data_out_0  input  DATA_W  FIFO 0 read data, valid the cycle after its read_enb
data_out_1  input  DATA_W  FIFO 1 read data, same timing
data_out_2  input  DATA_W  FIFO 2 read data, same timing
tx_ready  input  1  UART transmitter can accept a byte
read_enb_0  output  1  pop FIFO 0
read_enb_1  output  1  pop FIFO 1
read_enb_2  output  1  pop FIFO 2
tx_data  output  DATA_W  byte to transmitter
tx_valid  output  1  tx_data valid
busy  output  1  packet in progress (any state other than IDLE)
chan  output  2  channel being served; 2'b11 when idle
pkt_done  output  1  one-cycle pulse after the parity byte is accepted
pkt_abort  output  1  one-cycle pulse when a packet is dropped by soft reset

Behaviour:
- Reset (async, resetn low):
  - state=IDLE, rr_ptr=2 (channel 0 wins first).
  - All read_enb_x=0, tx_valid=0, tx_data=0, busy=0, chan=2'b11, pkt_done=0, pkt_abort=0.
- Packet format: byte0 header = {len[7:2], addr[1:0]}, then len payload bytes, then 1 parity byte. Total = len+2 bytes; len=0 gives 2 bytes.
- FSM states: IDLE, RD_REQ, RD_WAIT, SEND, DONE.
- IDLE:
  - Select the first channel with vld_out high, scanning rr_ptr+1, rr_ptr+2, rr_ptr (mod 3).
  - Latch sel, go to RD_REQ, set remaining=0 and hdr_pending=1.
- RD_REQ:
  - If vld_out[sel]=1: read_enb[sel]=1 for exactly this cycle, go to RD_WAIT.
  - Otherwise stall in RD_REQ with no read. The FIFO ran empty mid-packet; this is not an error.
- RD_WAIT: register data_out[sel] into tx_data, assert tx_valid, go to SEND.
  - If hdr_pending: remaining = data[7:2] + 1 (payload + parity), clear hdr_pending.
  - Otherwise: remaining -= 1.
- SEND: hold tx_data/tx_valid stable until tx_ready=1. On that handshake cycle tx_valid drops next cycle.
  - If remaining==0: go to DONE.
  - Otherwise: go to RD_REQ.
- DONE: pulse pkt_done, set rr_ptr=sel, go to IDLE.
- Read enables are combinational from state/sel (one-hot or zero, never two high).
- Throughput: at most one byte per 3 cycles with tx_ready held high. IDLE to first tx_valid takes 3 cycles.
- Soft reset of the selected channel in any non-IDLE state:
  - Next cycle: tx_valid=0, pkt_pulse pkt_abort=1, rr_ptr=sel, state=IDLE.
  - A byte already presented and not yet accepted is withdrawn.
  - Soft reset of a non-selected channel has no effect.
- Same cycle as SEND handshake and soft_reset[sel]: abort wins; pkt_done is not pulsed.
- Counter remaining is LEN_W+1 bits; len=63 gives remaining=64 with no overflow.
- chan = sel while busy, else 2'b11.

Decomposition:
- Shared package router_pkg:
  - FSM state encoding.
  - Header field positions (LEN_MSB=7, LEN_LSB=2).
  - NUM_CH=3 and CHAN_IDLE=2'b11.
- One sub-module: rr_arbiter_3. Inputs: request vector and rr_ptr. Outputs: grant index and grant_valid. Purely combinational.

Test Plan:
- Header 8'h05 (len=1, addr=1) + 8'hAA + parity 8'h5E in FIFO 0, tx_ready=1 → tx bytes 05,AA,5E; read_enb_0 pulses 3 times; pkt_done once; chan=0 throughout.
- All three FIFOs hold len=0 packets → served in order 0,1,2, then 0 again; never two read_enb high together.
- tx_ready low for 10 cycles during a payload byte → tx_data stable, tx_valid held, no extra read_enb.
- vld_out_1 drops mid-packet for 5 cycles → FSM stalls in RD_REQ with no read_enb, then resumes; byte count correct.
- soft_reset_2 asserted while serving channel 2 in SEND → tx_valid drops, pkt_abort pulses, next grant goes to channel 0.
- resetn asserted mid-packet, asynchronously between edges → all outputs return to reset values immediately; chan=2'b11.
